// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - run/pause/clear stopwatch engine, BCD count 00:00:00..99:59:59
// Optional lap-hold display freeze is enabled by defining LAP_HOLD_EN.
module stopwatch_core #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_ss,
  input  logic       key_clr,
`ifdef LAP_HOLD_EN
  input  logic       key_lap,
  output logic       lap_active,
`endif
  output logic [3:0] hr_h,
  output logic [3:0] hr_l,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // Digit index 0 = sec_l ... 5 = hr_h; per-digit rollover value.
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  logic [1:0]      state_q, state_d;
  logic            ss_dly_q, clr_dly_q;
  logic            ss_press, clr_press;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0][3:0] cnt_q, cnt_d;
  logic            inc, carry;
  logic            tick_q, wrap_q, running_q;
  logic [5:0][3:0] disp;

  assign ss_press  = key_ss  & ~ss_dly_q;
  assign clr_press = key_clr & ~clr_dly_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_press) state_d = S_RUN;
      S_RUN:   if (ss_press) state_d = S_PAUSE;
      S_PAUSE: begin
        if (clr_press)     state_d = S_IDLE;
        else if (ss_press) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A start/stop press in RUN pauses before the prescaler can advance.
  assign inc = (state_q == S_RUN) && !ss_press && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    if (state_d == S_IDLE)
      presc_d = '0;
    else if (state_q == S_RUN && !ss_press)
      presc_d = inc ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b0;
    if (state_d == S_IDLE) begin
      cnt_d = '0;
    end else if (inc) begin
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (carry) begin
          if (cnt_q[i] == DIGIT_MAX[i]) begin
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ss_dly_q  <= 1'b1;
      clr_dly_q <= 1'b1;
      presc_q   <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_dly_q  <= key_ss;
      clr_dly_q <= key_clr;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      tick_q    <= inc;
      wrap_q    <= inc & carry;
      running_q <= (state_d == S_RUN);
    end
  end

`ifdef LAP_HOLD_EN
  logic            lap_dly_q, lap_press;
  logic            lap_q, lap_d;
  logic [5:0][3:0] disp_q;

  assign lap_press = key_lap & ~lap_dly_q;

  always_comb begin
    lap_d = lap_q;
    if (state_d == S_IDLE)
      lap_d = 1'b0;
    else if (state_q == S_RUN && lap_press)
      lap_d = ~lap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_dly_q <= 1'b1;
      lap_q     <= 1'b0;
      disp_q    <= '0;
    end else begin
      lap_dly_q <= key_lap;
      lap_q     <= lap_d;
      disp_q    <= lap_d ? disp_q : cnt_d;
    end
  end

  assign lap_active = lap_q;
  assign disp       = disp_q;
`else
  assign disp = cnt_q;
`endif

  assign sec_l   = disp[0];
  assign sec_h   = disp[1];
  assign min_l   = disp[2];
  assign min_h   = disp[3];
  assign hr_l    = disp[4];
  assign hr_h    = disp[5];
  assign running = running_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - randomized self-checking bench for stopwatch_core (TICK_DIV=4)
// Define LAP_HOLD_EN for both bench and RTL to cover the lap-hold build.
module tb_stopwatch_core;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ss = 1'b0;
  logic       key_clr = 1'b0;
  logic       key_lap = 1'b0;
  logic [3:0] hr_h, hr_l, min_h, min_l, sec_h, sec_l;
  logic       running, tick, wrap;
`ifdef LAP_HOLD_EN
  logic       lap_active;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time kept as a plain seconds count.
  int m_state;
  int m_presc;
  int m_secs;
  int m_shown;
  bit m_ss_d, m_clr_d, m_lap_d, m_lap;
  bit m_tick, m_wrap;

  int wraps;

  always #5 clk = ~clk;

  stopwatch_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_ss    (key_ss),
    .key_clr   (key_clr),
`ifdef LAP_HOLD_EN
    .key_lap   (key_lap),
    .lap_active(lap_active),
`endif
    .hr_h      (hr_h),
    .hr_l      (hr_l),
    .min_h     (min_h),
    .min_l     (min_l),
    .sec_h     (sec_h),
    .sec_l     (sec_l),
    .running   (running),
    .tick      (tick),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bcd6(input int s);
    int h, m, c;
    h = s / 3600;
    m = (s / 60) % 60;
    c = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [23:0] digits();
    return {hr_h, hr_l, min_h, min_l, sec_h, sec_l};
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_secs = 0; m_shown = 0;
    m_ss_d = 1'b1; m_clr_d = 1'b1; m_lap_d = 1'b1; m_lap = 1'b0;
    m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  // 0 = IDLE, 1 = RUN, 2 = PAUSE
  task automatic model_step();
    bit ssp, clrp, lapp;
    int old_state;
    ssp  = key_ss  && !m_ss_d;
    clrp = key_clr && !m_clr_d;
    lapp = key_lap && !m_lap_d;
    m_ss_d = key_ss; m_clr_d = key_clr; m_lap_d = key_lap;
    old_state = m_state;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    case (m_state)
      0: if (ssp) m_state = 1;
      1: begin
        if (ssp) m_state = 2;
        else if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_tick  = 1'b1;
        end else m_presc++;
      end
      default: begin
        if (clrp) m_state = 0;
        else if (ssp) m_state = 1;
      end
    endcase
    if (m_tick) begin
      m_secs++;
      if (m_secs == 100 * 3600) begin
        m_secs = 0;
        m_wrap = 1'b1;
      end
    end
    if (m_state == 0) begin
      m_secs  = 0;
      m_presc = 0;
    end
`ifdef LAP_HOLD_EN
    if (old_state == 1 && lapp) m_lap = !m_lap;
    if (m_state == 0) m_lap = 1'b0;
    if (!m_lap) m_shown = m_secs;
`else
    if (lapp || old_state >= 0) m_shown = m_secs;
`endif
  endtask

  task automatic compare();
    check("digits", digits(), bcd6(m_shown));
    check("running", running, (m_state == 1));
    check("tick", tick, m_tick);
    check("wrap", wrap, m_wrap);
`ifdef LAP_HOLD_EN
    check("lap_active", lap_active, m_lap);
`endif
  endtask

  task automatic cycle(input logic ss, input logic clr, input logic lp);
    key_ss  = ss;
    key_clr = clr;
    key_lap = lp;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  initial begin
    model_reset();
    key_ss = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;

    // Key held through reset must not count as a press.
    repeat (5) cycle(1, 0, 0);
    check("held_through_reset", running, 1'b0);
    check("held_digits", digits(), 24'h0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("run_rise", running, 1'b1);

    repeat (40) cycle(0, 0, 0);
    check("ten_sec_digits", {sec_h, sec_l}, 8'h10);
    check("ten_sec_tick", tick, 1'b1);

    repeat (2) cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    check("pause_frozen", digits(), 24'h000010);
    check("pause_running", running, 1'b0);
    cycle(1, 0, 0);
    check("resume_running", running, 1'b1);
    cycle(0, 0, 0);
    check("resume_no_tick", tick, 1'b0);
    cycle(0, 0, 0);
    check("resume_tick", tick, 1'b1);
    check("resume_digits", digits(), 24'h000011);

    cycle(0, 1, 0);
    check("clr_in_run", running, 1'b1);
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    check("ssclr_run_pause", running, 1'b0);
    check("ssclr_run_digits", digits(), 24'h000011);
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    check("ssclr_pause_idle", digits(), 24'h0);
    check("ssclr_pause_run", running, 1'b0);

    // Preload 99:59:59 while paused, then resume into the wrap.
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    force dut.cnt_q = 24'h995959;
    m_secs  = 100 * 3600 - 1;
    m_shown = m_secs;
    cycle(0, 0, 0);
    release dut.cnt_q;
    check("preload", digits(), 24'h995959);
    cycle(1, 0, 0);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0);
      if (wrap) begin
        wraps++;
        check("wrap_digits", digits(), 24'h0);
        check("wrap_running", running, 1'b1);
      end
    end
    check("wrap_count", wraps, 1);

`ifdef LAP_HOLD_EN
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (12) cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (20) cycle(0, 0, 0);
    check("lap_hold", digits(), 24'h000003);
    check("lap_on", lap_active, 1'b1);
    cycle(0, 0, 1);
    check("lap_release", digits(), 24'h000008);
    check("lap_off", lap_active, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        key_ss = 1'b1;
        rst_n  = 1'b0;
        #1;
        model_reset();
        check("midrst_digits", digits(), 24'h0);
        check("midrst_running", running, 1'b0);
        check("midrst_tick", tick, 1'b0);
        check("midrst_wrap", wrap, 1'b0);
        #2;
        rst_n = 1'b1;
      end
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Time-keeping engine of the stopwatch. It sits directly upstream of the six-digit multiplexed seven-segment driver and feeds it hr_h/hr_l/min_h/min_l/sec_h/sec_l as BCD digits. It turns debounced start/stop and clear keys into run/pause/clear control through a 3-state FSM. A prescaler derives the 1 s tick, and cascaded BCD counters advance from 00:00:00 to 99:59:59 and wrap.

Parameters:
TICK_DIV, 50000000, clk cycles per counted second (>=2); sim benches use 4.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
key_ss  in  1  start/stop key, active-high level, synchronous, debounced upstream
key_clr  in  1  clear key, active-high level, synchronous, debounced upstream
hr_h  out  4  hours tens, BCD 0-9
hr_l  out  4  hours units, BCD 0-9
min_h  out  4  minutes tens, BCD 0-5
min_l  out  4  minutes units, BCD 0-9
sec_h  out  4  seconds tens, BCD 0-5
sec_l  out  4  seconds units, BCD 0-9
running  out  1  1 while FSM in RUN
tick  out  1  one-cycle pulse, registered, coincident with each time increment
wrap  out  1  one-cycle pulse on 99:59:59 -> 00:00:00

Behaviour:
- Reset (async, rst_n=0): all digits 0, running=0, tick=0, wrap=0, FSM=IDLE, prescaler=0; key delay regs reset to 1, so a key held through reset is not a press.
- Press detection: key_d <= key each cycle; press = key & ~key_d. Action is taken on the first clk edge that samples key=1 (with key_d=0). Holding a key gives one press only.
- FSM states: IDLE (zeroed, stopped), RUN, PAUSE.
  - IDLE + ss press -> RUN.
  - RUN + ss press -> PAUSE.
  - PAUSE + ss press -> RUN.
  - PAUSE + clr press -> IDLE.
  - clr in RUN or IDLE: ignored.
  - Simultaneous ss+clr in PAUSE: clr wins -> IDLE.
  - Simultaneous ss+clr in RUN: ss wins -> PAUSE.
- running is registered and equals (next state == RUN), so it rises on the same edge the FSM enters RUN.
- Entering IDLE zeroes all digits and the prescaler on that same edge.
- Prescaler: counts 0..TICK_DIV-1 only in RUN.
  - Holds its value in PAUSE, so resuming continues the partial second.
  - Sits at 0 in IDLE.
  - Increment condition: prescaler==TICK_DIV-1 while in RUN and no ss press that cycle. On that edge the prescaler returns to 0, digits increment, and tick=1 for one cycle.
  - From IDLE, the first increment happens exactly TICK_DIV cycles after the edge that entered RUN.
- BCD cascade, on each increment:
  - sec_l 9->0 carries to sec_h; sec_h 5->0 carries to min_l.
  - min_l 9->0 carries to min_h; min_h 5->0 carries to hr_l.
  - hr_l 9->0 carries to hr_h; hr_h 9->0.
- At 99:59:59 an increment produces 00:00:00 with wrap=1 on the same cycle as tick; FSM stays in RUN.
- Digits never take non-BCD values. All outputs are registered; no combinational input-to-output path.
- Mid-operation reset: immediate return to reset values regardless of state.

Optional Feature:
Macro LAP_HOLD_EN.
- When defined:
  - Adds input key_lap (1 bit, same timing rules as the other keys) and output lap_active (1 bit, reset 0).
  - A lap press in RUN toggles lap_active.
  - While lap_active=1, the six digit outputs stay frozen at the values present when the hold began; internal counters, tick and wrap keep operating.
  - Releasing the hold presents the live count on the next edge.
  - Lap presses in IDLE/PAUSE are ignored, but an existing hold stays active through PAUSE.
  - Entering IDLE clears lap_active and shows zeros.
- When undefined: no key_lap/lap_active ports; digit outputs always show the live count.

Test Plan:
- Reset with key_ss held high, then release rst_n -> no transition, running=0, digits 00:00:00 until key_ss drops and rises again.
- TICK_DIV=4, ss press -> running=1 next edge; tick pulses every 4 cycles; after 10 ticks sec_h=1, sec_l=0.
- Run to 10 s + 2 cycles, ss press, wait 20 cycles, ss press -> digits frozen at 00:00:10 during pause; next tick arrives 2 cycles after resume.
- Pause, then simultaneous ss+clr press -> FSM IDLE, all digits 0, running=0; clr alone during RUN -> no effect.
- Preload path via 359999 ticks (or force digits to 99:59:59) in RUN -> next tick gives 00:00:00, wrap=1 for exactly one cycle, running stays 1.
- LAP_HOLD_EN: lap press at 00:00:03 -> outputs hold 00:00:03 for 5 ticks; second lap press -> outputs show 00:00:08 next edge.
